// File: rtl/jtag_tap_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : jtag_tap_responder
//  Description : Oversampled IEEE 1149.1 TAP target running in the system
//                clock domain. TCK/TMS/TDI/TRST are synchronised and
//                edge-detected. The block provides a 5-bit IR and IDCODE,
//                BYPASS and USER data registers. The USER register has
//                capture and update handshakes to on-chip logic.
//  Revision    : 1.0 - initial release
// ============================================================================
module jtag_tap_responder #(
    parameter int                     IR_WIDTH     = 5,
    parameter int                     DR_WIDTH     = 41,
    parameter logic [31:0]            IDCODE_VALUE = 32'h249511C3,
    parameter logic [IR_WIDTH-1:0]    USER_IR      = 5'h11
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                tck_i,
    input  logic                tms_i,
    input  logic                tdi_i,
    input  logic                trst_ni,
    output logic                tdo_o,
    output logic                tdo_oe_o,
    output logic [IR_WIDTH-1:0] ir_o,
    output logic [3:0]          tap_state_o,
    output logic                dr_capture_o,
    input  logic [DR_WIDTH-1:0] dr_capture_data_i,
    output logic                dr_update_valid_o,
    output logic [DR_WIDTH-1:0] dr_update_data_o
);

    // TAP state encoding
    localparam logic [3:0] c_st_tlr      = 4'd0;
    localparam logic [3:0] c_st_rti      = 4'd1;
    localparam logic [3:0] c_st_sel_dr   = 4'd2;
    localparam logic [3:0] c_st_cap_dr   = 4'd3;
    localparam logic [3:0] c_st_sh_dr    = 4'd4;
    localparam logic [3:0] c_st_ex1_dr   = 4'd5;
    localparam logic [3:0] c_st_pause_dr = 4'd6;
    localparam logic [3:0] c_st_ex2_dr   = 4'd7;
    localparam logic [3:0] c_st_upd_dr   = 4'd8;
    localparam logic [3:0] c_st_sel_ir   = 4'd9;
    localparam logic [3:0] c_st_cap_ir   = 4'd10;
    localparam logic [3:0] c_st_sh_ir    = 4'd11;
    localparam logic [3:0] c_st_ex1_ir   = 4'd12;
    localparam logic [3:0] c_st_pause_ir = 4'd13;
    localparam logic [3:0] c_st_ex2_ir   = 4'd14;
    localparam logic [3:0] c_st_upd_ir   = 4'd15;

    // Fixed IR capture pattern and the IDCODE opcode (also the reset opcode)
    localparam logic [IR_WIDTH-1:0] c_ir_capture = IR_WIDTH'(5'b00101);
    localparam logic [IR_WIDTH-1:0] c_ir_idcode  = IR_WIDTH'(5'h01);
    // IEEE 1149.1 requires the IDCODE LSB to read as 1
    localparam logic [31:0]         c_idcode     = {IDCODE_VALUE[31:1], 1'b1};

    // Synchroniser and edge-detect stages
    logic r_tck_meta, r_tck_sync, r_tck_dly;
    logic r_tms_meta, r_tms_sync;
    logic r_tdi_meta, r_tdi_sync;
    logic r_trst_meta, r_trst_sync;

    // TAP state and registers
    logic [3:0]          r_state;
    logic [IR_WIDTH-1:0] r_ir_sr;
    logic [IR_WIDTH-1:0] r_ir;
    logic                r_dr_bypass;
    logic [31:0]         r_dr_idcode;
    logic [DR_WIDTH-1:0] r_dr_user;
    logic                r_tdo;
    logic                r_tdo_oe;
    logic                r_capture;
    logic                r_update_valid;
    logic [DR_WIDTH-1:0] r_update_data;

    // Combinational helpers
    logic       w_tck_rise;
    logic       w_tck_fall;
    logic       w_trst;
    logic [3:0] w_next_state;
    logic       w_sel_idcode;
    logic       w_sel_user;
    logic       w_dr_lsb;

    // Two-flop synchronisers for all pins plus the TCK edge-detect flop
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tck_meta  <= 1'b0;
            r_tck_sync  <= 1'b0;
            r_tck_dly   <= 1'b0;
            r_tms_meta  <= 1'b0;
            r_tms_sync  <= 1'b0;
            r_tdi_meta  <= 1'b0;
            r_tdi_sync  <= 1'b0;
            r_trst_meta <= 1'b1;
            r_trst_sync <= 1'b1;
        end else begin
            r_tck_meta  <= tck_i;
            r_tck_sync  <= r_tck_meta;
            r_tck_dly   <= r_tck_sync;
            r_tms_meta  <= tms_i;
            r_tms_sync  <= r_tms_meta;
            r_tdi_meta  <= tdi_i;
            r_tdi_sync  <= r_tdi_meta;
            r_trst_meta <= trst_ni;
            r_trst_sync <= r_trst_meta;
        end
    end

    // TMS/TDI are taken from the same stage that produces the TCK edge strobe
    assign w_tck_rise = r_tck_sync & ~r_tck_dly;
    assign w_tck_fall = ~r_tck_sync & r_tck_dly;
    assign w_trst     = ~r_trst_sync;

    // IEEE 1149.1 next-state table driven by the synchronised TMS
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_tlr:      w_next_state = r_tms_sync ? c_st_tlr      : c_st_rti;
            c_st_rti:      w_next_state = r_tms_sync ? c_st_sel_dr   : c_st_rti;
            c_st_sel_dr:   w_next_state = r_tms_sync ? c_st_sel_ir   : c_st_cap_dr;
            c_st_cap_dr:   w_next_state = r_tms_sync ? c_st_ex1_dr   : c_st_sh_dr;
            c_st_sh_dr:    w_next_state = r_tms_sync ? c_st_ex1_dr   : c_st_sh_dr;
            c_st_ex1_dr:   w_next_state = r_tms_sync ? c_st_upd_dr   : c_st_pause_dr;
            c_st_pause_dr: w_next_state = r_tms_sync ? c_st_ex2_dr   : c_st_pause_dr;
            c_st_ex2_dr:   w_next_state = r_tms_sync ? c_st_upd_dr   : c_st_sh_dr;
            c_st_upd_dr:   w_next_state = r_tms_sync ? c_st_sel_dr   : c_st_rti;
            c_st_sel_ir:   w_next_state = r_tms_sync ? c_st_tlr      : c_st_cap_ir;
            c_st_cap_ir:   w_next_state = r_tms_sync ? c_st_ex1_ir   : c_st_sh_ir;
            c_st_sh_ir:    w_next_state = r_tms_sync ? c_st_ex1_ir   : c_st_sh_ir;
            c_st_ex1_ir:   w_next_state = r_tms_sync ? c_st_upd_ir   : c_st_pause_ir;
            c_st_pause_ir: w_next_state = r_tms_sync ? c_st_ex2_ir   : c_st_pause_ir;
            c_st_ex2_ir:   w_next_state = r_tms_sync ? c_st_upd_ir   : c_st_sh_ir;
            c_st_upd_ir:   w_next_state = r_tms_sync ? c_st_sel_dr   : c_st_rti;
            default:       w_next_state = c_st_tlr;
        endcase
    end

    // Instruction decode: anything that is not IDCODE or USER selects BYPASS
    always_comb begin
        w_sel_idcode = (r_ir == c_ir_idcode);
        w_sel_user   = ~w_sel_idcode & (r_ir == USER_IR);
        if (w_sel_idcode) begin
            w_dr_lsb = r_dr_idcode[0];
        end else if (w_sel_user) begin
            w_dr_lsb = r_dr_user[0];
        end else begin
            w_dr_lsb = r_dr_bypass;
        end
    end

    // TAP controller: rising-edge shift/capture, falling-edge TDO and update
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state        <= c_st_tlr;
            r_ir_sr        <= '0;
            r_ir           <= c_ir_idcode;
            r_dr_bypass    <= 1'b0;
            r_dr_idcode    <= '0;
            r_dr_user      <= '0;
            r_tdo          <= 1'b0;
            r_tdo_oe       <= 1'b0;
            r_capture      <= 1'b0;
            r_update_valid <= 1'b0;
            r_update_data  <= '0;
        end else begin
            r_capture      <= 1'b0;
            r_update_valid <= 1'b0;

            // On-chip data is sampled in the cycle the capture strobe is high
            if (r_capture) begin
                r_dr_user <= dr_capture_data_i;
            end

            if (w_trst) begin
                // TRST abandons any shift in progress without an update
                r_state  <= c_st_tlr;
                r_ir     <= c_ir_idcode;
                r_tdo_oe <= 1'b0;
            end else if (w_tck_rise) begin
                case (r_state)
                    c_st_cap_ir: r_ir_sr <= c_ir_capture;
                    c_st_sh_ir:  r_ir_sr <= {r_tdi_sync, r_ir_sr[IR_WIDTH-1:1]};
                    c_st_cap_dr: begin
                        if (w_sel_idcode) begin
                            r_dr_idcode <= c_idcode;
                        end else if (w_sel_user) begin
                            r_capture <= 1'b1;
                        end else begin
                            r_dr_bypass <= 1'b0;
                        end
                    end
                    c_st_sh_dr: begin
                        if (w_sel_idcode) begin
                            r_dr_idcode <= {r_tdi_sync, r_dr_idcode[31:1]};
                        end else if (w_sel_user) begin
                            r_dr_user <= {r_tdi_sync, r_dr_user[DR_WIDTH-1:1]};
                        end else begin
                            r_dr_bypass <= r_tdi_sync;
                        end
                    end
                    default: ;
                endcase
                r_state <= w_next_state;
                if (w_next_state == c_st_tlr) begin
                    r_ir     <= c_ir_idcode;
                    r_tdo_oe <= 1'b0;
                end
            end else if (w_tck_fall) begin
                if (r_state == c_st_sh_ir) begin
                    r_tdo <= r_ir_sr[0];
                end else if (r_state == c_st_sh_dr) begin
                    r_tdo <= w_dr_lsb;
                end
                r_tdo_oe <= (r_state == c_st_sh_ir) || (r_state == c_st_sh_dr);
                if (r_state == c_st_upd_ir) begin
                    r_ir <= r_ir_sr;
                end
                if ((r_state == c_st_upd_dr) && (r_ir == USER_IR)) begin
                    r_update_data  <= r_dr_user;
                    r_update_valid <= 1'b1;
                end
            end
        end
    end

    assign tdo_o             = r_tdo;
    assign tdo_oe_o          = r_tdo_oe;
    assign ir_o              = r_ir;
    assign tap_state_o       = r_state;
    assign dr_capture_o      = r_capture;
    assign dr_update_valid_o = r_update_valid;
    assign dr_update_data_o  = r_update_data;

endmodule
`default_nettype wire

// File: tb/tb_jtag_tap_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_jtag_tap_responder
//  Description : Scoreboard bench for jtag_tap_responder. A JTAG host drives
//                TCK at 1/10 of clk_i. Expected TDO bits, capture strobes and
//                update words are queued and then checked by monitors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_tap_responder;

    localparam int DR_W = 41;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            tck_i;
    logic            tms_i;
    logic            tdi_i;
    logic            trst_ni;
    logic            tdo_o;
    logic            tdo_oe_o;
    logic [4:0]      ir_o;
    logic [3:0]      tap_state_o;
    logic            dr_capture_o;
    logic [DR_W-1:0] dr_capture_data_i;
    logic            dr_update_valid_o;
    logic [DR_W-1:0] dr_update_data_o;

    int checks = 0;
    int errors = 0;

    bit              q_tdo[$];
    bit              q_cap[$];
    logic [DR_W-1:0] q_upd[$];

    bit         exp_oe = 1'b0;
    logic [3:0] m_state = 4'd0;

    always #5 clk_i = ~clk_i;

    jtag_tap_responder dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .tck_i             (tck_i),
        .tms_i             (tms_i),
        .tdi_i             (tdi_i),
        .trst_ni           (trst_ni),
        .tdo_o             (tdo_o),
        .tdo_oe_o          (tdo_oe_o),
        .ir_o              (ir_o),
        .tap_state_o       (tap_state_o),
        .dr_capture_o      (dr_capture_o),
        .dr_capture_data_i (dr_capture_data_i),
        .dr_update_valid_o (dr_update_valid_o),
        .dr_update_data_o  (dr_update_data_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // IEEE 1149.1 reference transition table
    function automatic logic [3:0] tap_next(input logic [3:0] s, input bit tms);
        case (s)
            4'd0:  return tms ? 4'd0  : 4'd1;
            4'd1:  return tms ? 4'd2  : 4'd1;
            4'd2:  return tms ? 4'd9  : 4'd3;
            4'd3:  return tms ? 4'd5  : 4'd4;
            4'd4:  return tms ? 4'd5  : 4'd4;
            4'd5:  return tms ? 4'd8  : 4'd6;
            4'd6:  return tms ? 4'd7  : 4'd6;
            4'd7:  return tms ? 4'd8  : 4'd4;
            4'd8:  return tms ? 4'd2  : 4'd1;
            4'd9:  return tms ? 4'd0  : 4'd10;
            4'd10: return tms ? 4'd12 : 4'd11;
            4'd11: return tms ? 4'd12 : 4'd11;
            4'd12: return tms ? 4'd15 : 4'd13;
            4'd13: return tms ? 4'd14 : 4'd13;
            4'd14: return tms ? 4'd15 : 4'd11;
            default: return tms ? 4'd2 : 4'd1;
        endcase
    endfunction

    // TDO monitor: the host samples TDO on each TCK rise
    initial begin : mon_tdo
        bit e;
        forever begin
            @(posedge tck_i);
            check("tdo_oe", {63'b0, tdo_oe_o}, {63'b0, exp_oe});
            if (tdo_oe_o === 1'b1) begin
                if (q_tdo.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tdo_unexpected actual=%b required=no_shift", tdo_o);
                end else begin
                    e = q_tdo.pop_front();
                    check("tdo", {63'b0, tdo_o}, {63'b0, e});
                end
            end
        end
    end

    // Handshake monitor: capture strobes and update words
    initial begin : mon_hs
        logic [DR_W-1:0] u;
        forever begin
            @(negedge clk_i);
            if (dr_capture_o === 1'b1) begin
                checks++;
                if (q_cap.size() == 0) begin
                    errors++;
                    $display("FAIL capture_pulse actual=pulse required=none");
                end else begin
                    void'(q_cap.pop_front());
                end
            end
            if (dr_update_valid_o === 1'b1) begin
                if (q_upd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL update_pulse actual=pulse data=%h required=none", dr_update_data_o);
                end else begin
                    u = q_upd.pop_front();
                    check("update_data", {23'b0, dr_update_data_o}, {23'b0, u});
                end
            end
        end
    end

    // One TCK period: TMS/TDI set while TCK is low, five clk_i per half period
    task automatic tck_cycle(input bit tms, input bit tdi, input bit exp_tdo);
        logic [3:0] nxt;
        tms_i  = tms;
        tdi_i  = tdi;
        exp_oe = (m_state == 4'd4) || (m_state == 4'd11);
        if (exp_oe) q_tdo.push_back(exp_tdo);
        repeat (5) @(negedge clk_i);
        tck_i = 1'b1;
        nxt   = tap_next(m_state, tms);
        repeat (5) @(negedge clk_i);
        m_state = nxt;
        check("tap_state", {60'b0, tap_state_o}, {60'b0, m_state});
        tck_i = 1'b0;
    endtask

    // From RTI: load an IR opcode and return to RTI
    task automatic shift_ir(input logic [4:0] v);
        logic [4:0] cap;
        cap = 5'b00101;
        tck_cycle(1'b1, 1'b0, 1'b0);
        tck_cycle(1'b1, 1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tck_cycle(i == 4, v[i], cap[i]);
        tck_cycle(1'b1, 1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0, 1'b0);
        check("ir_o", {59'b0, ir_o}, {59'b0, v});
    endtask

    // From RTI: DR scan with optional pause after a bit or TRST at a bit
    task automatic shift_dr(input int n, input logic [63:0] tdi_v, input logic [63:0] exp_v,
                            input bit user, input int pause_after, input int abort_at);
        tck_cycle(1'b1, 1'b0, 1'b0);
        if (user) q_cap.push_back(1'b1);
        tck_cycle(1'b0, 1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                trst_ni = 1'b0;
                repeat (3) @(negedge clk_i);
                m_state = 4'd0;
                check("trst_state", {60'b0, tap_state_o}, 64'd0);
                check("trst_ir", {59'b0, ir_o}, 64'h01);
                check("trst_oe", {63'b0, tdo_oe_o}, 64'd0);
                trst_ni = 1'b1;
                repeat (4) @(negedge clk_i);
                return;
            end
            tck_cycle((i == n - 1) || (i == pause_after), tdi_v[i], exp_v[i]);
            if (i == pause_after && i != n - 1) begin
                tck_cycle(1'b0, 1'b0, 1'b0);
                tck_cycle(1'b0, 1'b0, 1'b0);
                tck_cycle(1'b0, 1'b0, 1'b0);
                tck_cycle(1'b1, 1'b0, 1'b0);
                tck_cycle(1'b0, 1'b0, 1'b0);
            end
        end
        if (user) q_upd.push_back(tdi_v[DR_W-1:0]);
        tck_cycle(1'b1, 1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0, 1'b0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin : main
        rst_i = 1'b1;
        tck_i = 1'b0;
        tms_i = 1'b0;
        tdi_i = 1'b0;
        trst_ni = 1'b1;
        dr_capture_data_i = '0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_state", {60'b0, tap_state_o}, 64'd0);
        check("rst_ir", {59'b0, ir_o}, 64'h01);
        check("rst_oe", {63'b0, tdo_oe_o}, 64'd0);
        check("rst_tdo", {63'b0, tdo_o}, 64'd0);
        check("rst_cap", {63'b0, dr_capture_o}, 64'd0);
        check("rst_upd_valid", {63'b0, dr_update_valid_o}, 64'd0);
        check("rst_upd_data", {23'b0, dr_update_data_o}, 64'd0);

        // IDCODE read after reset
        tck_cycle(1'b0, 1'b0, 1'b0);
        shift_dr(32, 64'd0, 64'h249511C3, 1'b0, -1, -1);

        // IR capture pattern and BYPASS one-bit delay
        shift_ir(5'h1F);
        shift_dr(5, 64'b01101, 64'b11010, 1'b0, -1, -1);

        // Five TMS=1 edges reach TLR and restore the IDCODE opcode
        for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, 1'b0);
        check("tlr_state", {60'b0, tap_state_o}, 64'd0);
        check("tlr_ir", {59'b0, ir_o}, 64'h01);
        tck_cycle(1'b0, 1'b0, 1'b0);

        // USER write/read
        shift_ir(5'h11);
        dr_capture_data_i = 41'h0AA_5555_AAAA;
        shift_dr(DR_W, 64'h1_2345_6789, 64'h0AA_5555_AAAA, 1'b1, -1, -1);
        for (int i = 0; i < 3; i++) tck_cycle(1'b0, 1'b0, 1'b0);
        check("upd_hold", {23'b0, dr_update_data_o}, 64'h1_2345_6789);

        // USER scan interrupted by a pause
        dr_capture_data_i = 41'h10F0F3C3CA;
        shift_dr(DR_W, 64'h0DEADBEEF5, 64'h10F0F3C3CA, 1'b1, 17, -1);
        check("pause_upd", {23'b0, dr_update_data_o}, 64'h0DEADBEEF5);

        // TRST during the 20th USER bit
        dr_capture_data_i = 41'h1FFFF00000;
        shift_dr(DR_W, 64'h0555555555, 64'h1FFFF00000, 1'b1, -1, 19);
        repeat (10) @(negedge clk_i);
        check("trst_upd_data", {23'b0, dr_update_data_o}, 64'h0DEADBEEF5);
        tck_cycle(1'b0, 1'b0, 1'b0);

        repeat (10) @(negedge clk_i);
        check("tdo_queue_empty", 64'(q_tdo.size()), 64'd0);
        check("cap_queue_empty", 64'(q_cap.size()), 64'd0);
        check("upd_queue_empty", 64'(q_upd.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
